simmem_wresp_release_scheduler: RTL and testbench
=================================================

Name: simmem_wresp_release_scheduler

Overview:
- Delay scheduler driving the release-enable vector of the write-response bank.
- Snoops each accepted reservation (slot address plus requested delay) and counts the delay down per slot. It then asserts the slot's release enable until the bank reports that slot released.
- Sits between the request front-end and the write-response bank. Models per-transaction memory latency.

Parameters:
- Capacity, 16, number of bank slots; equals bank total capacity.
- AddrWidth, 4, slot address width; equals $clog2(Capacity).
- DelayWidth, 8, width of the per-transaction delay value in cycles.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- res_valid_i  input  1  reservation request valid (snooped).
- res_ready_i  input  1  reservation request ready (snooped from bank).
- res_addr_i  input  AddrWidth  slot address granted by the bank.
- delay_i  input  DelayWidth  delay for this reservation, in cycles.
- released_addr_onehot_i  input  Capacity  one-hot slot released by bank this cycle.
- release_en_o  output  Capacity  multi-hot; bit i high means slot i may be released.
- occupancy_o  output  AddrWidth+1  number of slots not FREE.
- error_o  output  1  sticky protocol-error flag.

Behaviour:
- Interface: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Per-slot state: FREE, COUNTING, RELEASABLE. Per-slot counter of DelayWidth bits.
- Reset: all slots FREE, counters 0. release_en_o=0, occupancy_o=0, error_o=0.
- Reservation accepted when res_valid_i && res_ready_i (cycle t).
  - Slot res_addr_i loads counter=delay_i.
  - State becomes COUNTING, or RELEASABLE directly if delay_i==0.
- COUNTING: counter decrements by 1 each cycle. When counter==1, next state is RELEASABLE with counter 0.
- Latency: release_en_o[a] first high in cycle t+1+delay_i. delay_i=0 gives t+1; delay_i=255 gives t+256. No wrap; delay is exact.
- release_en_o[i] = (state[i]==RELEASABLE), registered. Stays high until release.
- Release: released_addr_onehot_i[i] high while RELEASABLE sets slot FREE next cycle. release_en_o[i] low from t+1.
- Boundary and error conditions:
  - Release on a slot that is not RELEASABLE: ignored, state unchanged, error_o set.
  - Non-one-hot released_addr_onehot_i (>1 bit): all set bits are processed individually, error_o set.
  - Reservation on a slot that is not FREE: overwrites the slot, error_o set.
  - Same cycle, same slot, release plus reservation: the release is legal. The reservation wins and the slot reloads; no error.
  - Full: 16 slots non-FREE. The scheduler never backpressures; the bank deasserts ready.
- occupancy_o: registered count of non-FREE slots.
  - Updated as +1 per accepted reservation into a FREE slot.
  - Updated as -1 per legal release not coinciding with a reservation on the same slot.
  - Never exceeds Capacity.
- error_o is sticky until reset.
- Reset asserted mid-count: all slots immediately FREE and outputs 0 (asynchronous). No pending release survives reset.

Optional Feature:
- Macro SIMMEM_WRESP_SCHED_STALL_EN.
- Defined: adds input port stall_i (1 bit).
  - While stall_i is high, all COUNTING counters hold and no COUNTING→RELEASABLE transition occurs.
  - Reservations and releases still proceed normally.
  - Latency grows by the number of stalled cycles. A delay_i==0 reservation still becomes RELEASABLE at t+1.
- Undefined: no stall_i port; counters always run.

Test Plan:
- Reset, then reserve slot 3 with delay 5 at cycle 10 → release_en_o=0x0008 first at cycle 16; occupancy_o=1.
- Reserve slot 0 with delay 0 at cycle 2 → release_en_o[0] high at cycle 3. Pulse released_addr_onehot_i=0x0001 at cycle 4 → bit clears at cycle 5, occupancy_o=0, error_o=0.
- Fill all 16 slots with delays 1..16 on consecutive cycles 0..15 → each slot i becomes releasable at cycle 2i+2; occupancy_o=16. Release each as soon as it is enabled → occupancy_o returns to 0.
- Pulse released_addr_onehot_i=0x0020 while slot 5 is COUNTING → slot keeps counting, error_o=1 from next cycle and stays high.
- Same cycle: release slot 7 (RELEASABLE) and reserve slot 7 with delay 2 → slot COUNTING, release_en_o[7] low, high again 3 cycles later, occupancy unchanged, error_o=0.
- With SIMMEM_WRESP_SCHED_STALL_EN: reserve delay 4, hold stall_i high for 3 cycles mid-count → release_en_o asserted 3 cycles later than without stall.

Source files
------------

// File: rtl/simmem_wresp_release_scheduler.sv
// Per-slot delay scheduler driving the write-response bank release-enable vector.
// Optional stall input (counters hold) is enabled by defining SIMMEM_WRESP_SCHED_STALL_EN.
module simmem_wresp_release_scheduler #(
    parameter int unsigned Capacity   = 16,
    parameter int unsigned AddrWidth  = 4,
    parameter int unsigned DelayWidth = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
`ifdef SIMMEM_WRESP_SCHED_STALL_EN
    input  logic                  stall_i,
`endif
    input  logic                  res_valid_i,
    input  logic                  res_ready_i,
    input  logic [AddrWidth-1:0]  res_addr_i,
    input  logic [DelayWidth-1:0] delay_i,
    input  logic [Capacity-1:0]   released_addr_onehot_i,
    output logic [Capacity-1:0]   release_en_o,
    output logic [AddrWidth:0]    occupancy_o,
    output logic                  error_o
);

    typedef enum logic [1:0] {StFree, StCounting, StReleasable} slot_state_e;

    slot_state_e           state_q [Capacity];
    slot_state_e           state_d [Capacity];
    logic [DelayWidth-1:0] cnt_q   [Capacity];
    logic [DelayWidth-1:0] cnt_d   [Capacity];
    logic [AddrWidth:0]    occupancy_q, occupancy_d;
    logic                  error_q, error_d;
    logic                  stall;
    logic                  res_fire;
    logic                  rel_hit, res_hit;

`ifdef SIMMEM_WRESP_SCHED_STALL_EN
    assign stall = stall_i;
`else
    assign stall = 1'b0;
`endif

    assign res_fire = res_valid_i && res_ready_i;

    always_comb begin
        error_d     = error_q;
        occupancy_d = '0;
        rel_hit     = 1'b0;
        res_hit     = 1'b0;
        // More than one release bit set in a cycle is a protocol error.
        if ((released_addr_onehot_i & (released_addr_onehot_i - Capacity'(1))) != '0) begin
            error_d = 1'b1;
        end
        for (int unsigned i = 0; i < Capacity; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            rel_hit    = released_addr_onehot_i[i];
            res_hit    = res_fire && (res_addr_i == AddrWidth'(i));

            if (rel_hit) begin
                if (state_q[i] == StReleasable) begin
                    state_d[i] = StFree;
                end else begin
                    error_d = 1'b1;
                end
            end

            if (state_q[i] == StCounting && !stall) begin
                if (cnt_q[i] <= DelayWidth'(1)) begin
                    state_d[i] = StReleasable;
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] - DelayWidth'(1);
                end
            end

            // A reservation overrides everything; it is legal only into a slot that is
            // free or being freed in this same cycle.
            if (res_hit) begin
                if (state_q[i] != StFree && !(rel_hit && state_q[i] == StReleasable)) begin
                    error_d = 1'b1;
                end
                cnt_d[i]   = delay_i;
                state_d[i] = (delay_i == '0) ? StReleasable : StCounting;
            end

            if (state_d[i] != StFree) begin
                occupancy_d = occupancy_d + (AddrWidth + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Capacity; i++) begin
                state_q[i] <= StFree;
                cnt_q[i]   <= '0;
            end
            occupancy_q <= '0;
            error_q     <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < Capacity; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            occupancy_q <= occupancy_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        release_en_o = '0;
        for (int unsigned i = 0; i < Capacity; i++) begin
            release_en_o[i] = (state_q[i] == StReleasable);
        end
    end

    assign occupancy_o = occupancy_q;
    assign error_o     = error_q;

endmodule

// File: tb/tb_simmem_wresp_release_scheduler.sv
// Scoreboard bench: reservations push the expected first-release cycle per slot, and a
// negedge monitor pops entries as release_en_o bits rise.
module tb_simmem_wresp_release_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
`ifdef SIMMEM_WRESP_SCHED_STALL_EN
    logic        stall_i = 1'b0;
`endif
    logic        res_valid_i = 1'b0;
    logic        res_ready_i = 1'b0;
    logic [3:0]  res_addr_i = '0;
    logic [7:0]  delay_i = '0;
    logic [15:0] released_addr_onehot_i = '0;
    logic [15:0] release_en_o;
    logic [4:0]  occupancy_o;
    logic        error_o;

    typedef struct {
        int addr;
        int due;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] prev_en = '0;
    int          mon_idx;

    simmem_wresp_release_scheduler dut (
        .clk_i                  (clk_i),
        .rst_ni                 (rst_ni),
`ifdef SIMMEM_WRESP_SCHED_STALL_EN
        .stall_i                (stall_i),
`endif
        .res_valid_i            (res_valid_i),
        .res_ready_i            (res_ready_i),
        .res_addr_i             (res_addr_i),
        .delay_i                (delay_i),
        .released_addr_onehot_i (released_addr_onehot_i),
        .release_en_o           (release_en_o),
        .occupancy_o            (occupancy_o),
        .error_o                (error_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Scoreboard monitor: every rising enable must match a pending entry due this cycle.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            prev_en = '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (release_en_o[i] && !prev_en[i]) begin
                    mon_idx = -1;
                    foreach (exp_q[j]) if (mon_idx < 0 && exp_q[j].addr == i) mon_idx = j;
                    checks++;
                    if (mon_idx < 0) begin
                        errors++;
                        $display("FAIL sb_unexpected slot %0d rose at cycle %0d, none pending", i, cyc);
                    end else begin
                        if (exp_q[mon_idx].due !== cyc) begin
                            errors++;
                            $display("FAIL sb_latency slot %0d rose at cycle %0d required %0d",
                                     i, cyc, exp_q[mon_idx].due);
                        end
                        exp_q.delete(mon_idx);
                    end
                end
            end
            for (int j = exp_q.size() - 1; j >= 0; j--) begin
                if (exp_q[j].due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_missing slot %0d not enabled by cycle %0d required %0d",
                             exp_q[j].addr, cyc, exp_q[j].due);
                    exp_q.delete(j);
                end
            end
            prev_en = release_en_o;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic reserve(input int a, input int d, input int extra);
        exp_t e;
        res_valid_i = 1'b1;
        res_ready_i = 1'b1;
        res_addr_i  = 4'(a);
        delay_i     = 8'(d);
        e.addr      = a;
        e.due       = cyc + 1 + d + extra;
        exp_q.push_back(e);
        step();
        res_valid_i = 1'b0;
        res_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #2;
        checks += 3;
        if (release_en_o !== 16'h0) begin errors++; $display("FAIL reset_en got %h required 0000", release_en_o); end
        if (occupancy_o !== 5'd0) begin errors++; $display("FAIL reset_occ got %0d required 0", occupancy_o); end
        if (error_o !== 1'b0) begin errors++; $display("FAIL reset_err got %0b required 0", error_o); end
        step();
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_single();
        int t;
        t = cyc;
        reserve(3, 5, 0);
        while (cyc < t + 5) step();
        checks += 2;
        if (release_en_o !== 16'h0000) begin errors++; $display("FAIL single_early got %h required 0000", release_en_o); end
        if (occupancy_o !== 5'd1) begin errors++; $display("FAIL single_occ got %0d required 1", occupancy_o); end
        step();
        checks++;
        if (release_en_o !== 16'h0008) begin errors++; $display("FAIL single_en got %h required 0008", release_en_o); end
        released_addr_onehot_i = 16'h0008;
        step();
        released_addr_onehot_i = '0;
        checks += 2;
        if (release_en_o !== 16'h0000) begin errors++; $display("FAIL single_clr got %h required 0000", release_en_o); end
        if (occupancy_o !== 5'd0) begin errors++; $display("FAIL single_occ0 got %0d required 0", occupancy_o); end
    endtask

    task automatic test_delay_zero();
        reserve(0, 0, 0);
        checks++;
        if (release_en_o !== 16'h0001) begin errors++; $display("FAIL zero_en got %h required 0001", release_en_o); end
        step();
        released_addr_onehot_i = 16'h0001;
        step();
        released_addr_onehot_i = '0;
        checks += 3;
        if (release_en_o !== 16'h0000) begin errors++; $display("FAIL zero_clr got %h required 0000", release_en_o); end
        if (occupancy_o !== 5'd0) begin errors++; $display("FAIL zero_occ got %0d required 0", occupancy_o); end
        if (error_o !== 1'b0) begin errors++; $display("FAIL zero_err got %0b required 0", error_o); end
    endtask

    task automatic test_fill();
        logic [15:0] sel;
        for (int i = 0; i < 16; i++) reserve(i, i + 1, 0);
        checks++;
        if (occupancy_o !== 5'd16) begin errors++; $display("FAIL fill_occ got %0d required 16", occupancy_o); end
        for (int k = 0; k < 200 && occupancy_o != 5'd0; k++) begin
            sel = release_en_o & (~release_en_o + 16'd1);
            released_addr_onehot_i = sel;
            step();
        end
        released_addr_onehot_i = '0;
        checks += 3;
        if (occupancy_o !== 5'd0) begin errors++; $display("FAIL fill_drain got %0d required 0", occupancy_o); end
        if (release_en_o !== 16'h0) begin errors++; $display("FAIL fill_en got %h required 0000", release_en_o); end
        if (error_o !== 1'b0) begin errors++; $display("FAIL fill_err got %0b required 0", error_o); end
    endtask

    task automatic test_same_slot();
        int t;
        exp_t e;
        t = cyc;
        reserve(7, 0, 0);
        released_addr_onehot_i = 16'h0080;
        res_valid_i = 1'b1;
        res_ready_i = 1'b1;
        res_addr_i  = 4'd7;
        delay_i     = 8'd2;
        e.addr = 7;
        e.due  = cyc + 3;
        exp_q.push_back(e);
        step();
        released_addr_onehot_i = '0;
        res_valid_i = 1'b0;
        res_ready_i = 1'b0;
        checks += 3;
        if (release_en_o[7] !== 1'b0) begin errors++; $display("FAIL same_en_low got %b required 0", release_en_o[7]); end
        if (occupancy_o !== 5'd1) begin errors++; $display("FAIL same_occ got %0d required 1", occupancy_o); end
        if (error_o !== 1'b0) begin errors++; $display("FAIL same_err got %0b required 0", error_o); end
        while (cyc < t + 4) step();
        checks++;
        if (release_en_o !== 16'h0080) begin errors++; $display("FAIL same_en_high got %h required 0080", release_en_o); end
        released_addr_onehot_i = 16'h0080;
        step();
        released_addr_onehot_i = '0;
        checks++;
        if (occupancy_o !== 5'd0) begin errors++; $display("FAIL same_occ0 got %0d required 0", occupancy_o); end
    endtask

    task automatic test_overwrite();
        res_valid_i = 1'b1;
        res_ready_i = 1'b1;
        res_addr_i  = 4'd4;
        delay_i     = 8'd5;
        step();
        reserve(4, 1, 0);
        checks += 3;
        if (error_o !== 1'b1) begin errors++; $display("FAIL ovw_err got %0b required 1", error_o); end
        if (occupancy_o !== 5'd1) begin errors++; $display("FAIL ovw_occ got %0d required 1", occupancy_o); end
        if (release_en_o !== 16'h0) begin errors++; $display("FAIL ovw_early got %h required 0000", release_en_o); end
        step();
        checks++;
        if (release_en_o !== 16'h0010) begin errors++; $display("FAIL ovw_en got %h required 0010", release_en_o); end
        released_addr_onehot_i = 16'h0010;
        step();
        released_addr_onehot_i = '0;
        checks++;
        if (occupancy_o !== 5'd0) begin errors++; $display("FAIL ovw_occ0 got %0d required 0", occupancy_o); end
    endtask

    task automatic test_multi_release();
        reserve(1, 0, 0);
        reserve(2, 0, 0);
        released_addr_onehot_i = 16'h0006;
        step();
        released_addr_onehot_i = '0;
        checks += 3;
        if (release_en_o !== 16'h0) begin errors++; $display("FAIL multi_en got %h required 0000", release_en_o); end
        if (occupancy_o !== 5'd0) begin errors++; $display("FAIL multi_occ got %0d required 0", occupancy_o); end
        if (error_o !== 1'b1) begin errors++; $display("FAIL multi_err got %0b required 1", error_o); end
    endtask

    task automatic test_bad_release();
        int t;
        t = cyc;
        reserve(5, 10, 0);
        step();
        released_addr_onehot_i = 16'h0020;
        step();
        released_addr_onehot_i = '0;
        checks += 3;
        if (error_o !== 1'b1) begin errors++; $display("FAIL bad_err got %0b required 1", error_o); end
        if (release_en_o !== 16'h0) begin errors++; $display("FAIL bad_en got %h required 0000", release_en_o); end
        if (occupancy_o !== 5'd1) begin errors++; $display("FAIL bad_occ got %0d required 1", occupancy_o); end
        while (cyc < t + 11) step();
        checks += 2;
        if (release_en_o !== 16'h0020) begin errors++; $display("FAIL bad_late_en got %h required 0020", release_en_o); end
        if (error_o !== 1'b1) begin errors++; $display("FAIL bad_sticky got %0b required 1", error_o); end
        released_addr_onehot_i = 16'h0020;
        step();
        released_addr_onehot_i = '0;
    endtask

`ifdef SIMMEM_WRESP_SCHED_STALL_EN
    task automatic test_stall();
        int t;
        t = cyc;
        reserve(6, 4, 3);
        step();
        stall_i = 1'b1;
        repeat (3) step();
        stall_i = 1'b0;
        while (cyc < t + 7) step();
        checks++;
        if (release_en_o !== 16'h0) begin errors++; $display("FAIL stall_early got %h required 0000", release_en_o); end
        step();
        checks++;
        if (release_en_o !== 16'h0040) begin errors++; $display("FAIL stall_en got %h required 0040", release_en_o); end
        released_addr_onehot_i = 16'h0040;
        step();
        released_addr_onehot_i = '0;
    endtask
`endif

    task automatic test_reset_mid_count();
        reserve(9, 20, 0);
        repeat (5) step();
        rst_ni = 1'b0;
        #1;
        exp_q.delete();
        checks += 2;
        if (occupancy_o !== 5'd0) begin errors++; $display("FAIL mrst_occ got %0d required 0", occupancy_o); end
        if (release_en_o !== 16'h0) begin errors++; $display("FAIL mrst_en got %h required 0000", release_en_o); end
        step();
        rst_ni = 1'b1;
        repeat (25) step();
        checks += 2;
        if (release_en_o !== 16'h0) begin errors++; $display("FAIL mrst_late got %h required 0000", release_en_o); end
        if (occupancy_o !== 5'd0) begin errors++; $display("FAIL mrst_occ_late got %0d required 0", occupancy_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_delay_zero();
        test_fill();
        test_same_slot();
        test_overwrite();
        do_reset();
        test_multi_release();
        do_reset();
        test_bad_release();
        do_reset();
`ifdef SIMMEM_WRESP_SCHED_STALL_EN
        test_stall();
`endif
        test_reset_mid_count();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_pending got %0d entries required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
